// File: rtl/usb_pkg.sv
// Shared constants for the usb core endpoint logic: handshake codes,
// IN transmitter state encoding and the default packet size.
package usb_pkg;

    localparam logic [1:0] HS_ACK   = 2'b00;
    localparam logic [1:0] HS_NONE  = 2'b01;
    localparam logic [1:0] HS_NAK   = 2'b10;
    localparam logic [1:0] HS_STALL = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READY    = 3'd1;
    localparam logic [2:0] ST_FETCH    = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_WAIT_END = 3'd4;

    localparam int unsigned MAX_PKT_DEF = 64;

endpackage

// File: rtl/usb_edge_det.sv
// Single-bit rising-edge detector; a falling edge is obtained by feeding
// the inverted signal.
module usb_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // remember last cycle's level
    always_ff @(posedge i_clk) begin
        if (i_rst) r_prev <= 1'b0;
        else       r_prev <= i_sig;
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/usb_in_ep_tx.sv
// IN endpoint transmitter: splits a pending transfer held in a byte store
// into MAX_PKT packets, handles DATA0/1 toggling, ZLPs and retransmission.
module usb_in_ep_tx
    import usb_pkg::*;
#(
    parameter int unsigned EP_NUM  = 0,
    parameter int unsigned MAX_PKT = MAX_PKT_DEF,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             clk_48,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_len,
    input  logic             load_toggle,
    input  logic             load_zlp,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    input  logic [3:0]       endpoint,
    input  logic             direction_in,
    input  logic             setup,
    input  logic             transaction_active,
    input  logic             data_strobe,
    input  logic             success,
    output logic             data_toggle,
    output logic [1:0]       handshake,
    output logic [7:0]       data_in,
    output logic             data_in_valid
);

    localparam int unsigned EW = LEN_W + 8;
    localparam logic [EW-1:0] MAXP_EXT = EW'(MAX_PKT);

    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_base;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_rd_addr;
    logic             r_zlp_pend;
    logic             r_toggle;
    logic             r_busy;
    logic             r_done;
    logic             r_succ;

    logic             w_strobe_rise;
    logic             w_ta_rise;
    logic             w_ta_fall;
    logic             w_ta_n;
    logic [EW-1:0]    w_rem_ext;
    logic [LEN_W-1:0] w_pkt_len;
    logic             w_token_in;
    logic             w_setup_abort;
    logic             w_load_zlp;
    logic             w_sending;

    usb_edge_det u_strobe_det (
        .i_clk  (clk_48),
        .i_rst  (rst),
        .i_sig  (data_strobe),
        .o_rise (w_strobe_rise)
    );

    usb_edge_det u_ta_rise_det (
        .i_clk  (clk_48),
        .i_rst  (rst),
        .i_sig  (transaction_active),
        .o_rise (w_ta_rise)
    );

    assign w_ta_n = ~transaction_active;

    usb_edge_det u_ta_fall_det (
        .i_clk  (clk_48),
        .i_rst  (rst),
        .i_sig  (w_ta_n),
        .o_rise (w_ta_fall)
    );

    assign w_rem_ext     = EW'(r_remaining);
    assign w_pkt_len     = (w_rem_ext < MAXP_EXT) ? r_remaining : MAXP_EXT[LEN_W-1:0];
    assign w_token_in    = w_ta_rise && (endpoint == 4'(EP_NUM)) && direction_in && !setup;
    assign w_setup_abort = w_ta_rise && (endpoint == 4'(EP_NUM)) && setup;
    assign w_load_zlp    = load_zlp && (load_len != '0) && ((32'(load_len) % MAX_PKT) == 32'd0);

    // transfer/packet sequencing; SETUP abort beats everything, stall freezes the FSM
    always_ff @(posedge clk_48) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_remaining <= '0;
            r_cnt       <= '0;
            r_rd_addr   <= '0;
            r_zlp_pend  <= 1'b0;
            r_toggle    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_succ      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_setup_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else if (!stall) begin
                if (success && (r_state != ST_IDLE) && (r_state != ST_READY))
                    r_succ <= 1'b1;
                case (r_state)
                    ST_IDLE: begin
                        if (load) begin
                            r_base      <= '0;
                            r_remaining <= load_len;
                            r_toggle    <= load_toggle;
                            r_zlp_pend  <= w_load_zlp;
                            r_busy      <= 1'b1;
                            r_state     <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (w_token_in) begin
                            r_rd_addr <= r_base;
                            r_cnt     <= '0;
                            r_succ    <= 1'b0;
                            r_state   <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_state <= w_ta_fall ? ST_READY : ST_SEND;
                    end
                    ST_SEND: begin
                        // a host that gives up mid-packet gets the same packet again
                        if (w_ta_fall) begin
                            r_state <= ST_READY;
                        end else if (w_pkt_len == '0) begin
                            r_state <= ST_WAIT_END;
                        end else if (w_strobe_rise) begin
                            r_rd_addr <= r_rd_addr + LEN_W'(1);
                            r_cnt     <= r_cnt + LEN_W'(1);
                            if ((r_cnt + LEN_W'(1)) == w_pkt_len)
                                r_state <= ST_WAIT_END;
                        end
                    end
                    ST_WAIT_END: begin
                        if (w_ta_fall) begin
                            if (r_succ || success) begin
                                r_base      <= r_base + w_pkt_len;
                                r_remaining <= r_remaining - w_pkt_len;
                                r_toggle    <= ~r_toggle;
                                if (r_remaining != w_pkt_len) begin
                                    r_state <= ST_READY;
                                end else if (r_zlp_pend) begin
                                    r_zlp_pend <= 1'b0;
                                    r_state    <= ST_READY;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= ST_IDLE;
                                end
                            end else begin
                                r_state <= ST_READY;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_sending     = (r_state == ST_SEND) && (w_pkt_len != '0) && !stall;
    assign data_in_valid = w_sending;
    assign data_in       = w_sending ? rd_data : '0;
    assign handshake     = stall ? HS_STALL : ((r_state == ST_IDLE) ? HS_NAK : HS_ACK);
    assign busy          = r_busy;
    assign done          = r_done;
    assign rd_addr       = r_rd_addr;
    assign data_toggle   = r_toggle;

endmodule

// File: tb/tb_usb_in_ep_tx.sv
// Bench for usb_in_ep_tx: emulates the usb core and a synchronous byte store,
// plans expected packets from the transfer rules and checks every cycle.
module tb_usb_in_ep_tx;
    import usb_pkg::*;

    localparam int unsigned LW   = 8;
    localparam int unsigned MAXP = 64;
    localparam int unsigned EP   = 0;

    logic          clk_48 = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [LW-1:0] load_len = '0;
    logic          load_toggle = 1'b0;
    logic          load_zlp = 1'b0;
    logic          stall = 1'b0;
    logic          busy, done;
    logic [LW-1:0] rd_addr;
    logic [7:0]    rd_data = '0;
    logic [3:0]    endpoint = '0;
    logic          direction_in = 1'b0;
    logic          setup = 1'b0;
    logic          transaction_active = 1'b0;
    logic          data_strobe = 1'b0;
    logic          success = 1'b0;
    logic          data_toggle;
    logic [1:0]    handshake;
    logic [7:0]    data_in;
    logic          data_in_valid;

    usb_in_ep_tx #(.EP_NUM(EP), .MAX_PKT(MAXP), .LEN_W(LW)) dut (
        .clk_48(clk_48), .rst(rst), .load(load), .load_len(load_len),
        .load_toggle(load_toggle), .load_zlp(load_zlp), .stall(stall),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .endpoint(endpoint), .direction_in(direction_in), .setup(setup),
        .transaction_active(transaction_active), .data_strobe(data_strobe),
        .success(success), .data_toggle(data_toggle), .handshake(handshake),
        .data_in(data_in), .data_in_valid(data_in_valid)
    );

    always #5 clk_48 = ~clk_48;

    logic [7:0] mem [256];
    always @(posedge clk_48) rd_data <= mem[rd_addr];

    int n_cmp = 0;
    int n_bad = 0;

    // expected-state model, updated on the negedge whose inputs cause the change
    bit m_busy = 1'b0, m_toggle = 1'b0, m_done = 1'b0, m_may_send = 1'b0, chk_en = 1'b0;
    int pk_len [8];
    int pk_tog [8];
    int pk_addr[8];
    int npk = 0;
    logic [7:0] cap [80];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(posedge clk_48) begin
        #1;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("handshake", 32'(handshake), 32'(stall ? HS_STALL : (m_busy ? HS_ACK : HS_NAK)));
            chk("done", 32'(done), 32'(m_done));
            if (m_busy) chk("data_toggle", 32'(data_toggle), 32'(m_toggle));
            if (!m_may_send) chk("valid_outside_in", 32'(data_in_valid), 32'd0);
            m_done = 1'b0;
        end
    end

    // packet plan straight from the transfer rules
    task automatic plan(input int len, input bit tog, input bit zlp);
        int rem, addr, p;
        bit t;
        npk = 0; rem = len; addr = 0; t = tog;
        if (len == 0) begin
            pk_len[0] = 0; pk_tog[0] = int'(t); pk_addr[0] = 0; npk = 1;
        end else begin
            while (rem > 0) begin
                p = (rem < MAXP) ? rem : MAXP;
                pk_len[npk] = p; pk_tog[npk] = int'(t); pk_addr[npk] = addr; npk++;
                addr += p; rem -= p; t = !t;
            end
            if (zlp && (len % MAXP) == 0) begin
                pk_len[npk] = 0; pk_tog[npk] = int'(t); pk_addr[npk] = addr; npk++;
            end
        end
    endtask

    task automatic do_load(input int len, input bit tog, input bit zlp);
        @(negedge clk_48);
        load = 1'b1; load_len = 8'(len); load_toggle = tog; load_zlp = zlp;
        m_busy = 1'b1; m_toggle = tog;
        plan(len, tog, zlp);
        @(negedge clk_48);
        load = 1'b0;
        @(negedge clk_48);
    endtask

    // one IN transaction as the core would run it
    task automatic do_in(input logic [3:0] ep, input bit ack, input bit adv, input bit last,
                         output int n, output logic [1:0] hs, output logic tg, output logic [7:0] ra);
        @(negedge clk_48);
        endpoint = ep; direction_in = 1'b1; setup = 1'b0; transaction_active = 1'b1;
        m_may_send = (ep == 4'(EP));
        repeat (3) @(negedge clk_48);
        hs = handshake; tg = data_toggle; ra = rd_addr; n = 0;
        while (data_in_valid && n < 80) begin
            cap[n] = data_in; n++;
            data_strobe = 1'b1;
            @(negedge clk_48);
            data_strobe = 1'b0;
            repeat (3) @(negedge clk_48);
        end
        if (ack) begin
            success = 1'b1;
            @(negedge clk_48);
            success = 1'b0;
        end
        transaction_active = 1'b0; m_may_send = 1'b0;
        if (adv) begin
            m_toggle = !m_toggle;
            if (last) begin m_busy = 1'b0; m_done = 1'b1; end
        end
        repeat (2) @(negedge clk_48);
    endtask

    task automatic check_pkt(input string tag, input int i, input int n, input logic [1:0] hs,
                             input logic tg, input logic [7:0] ra);
        chk({tag, "_hs"}, 32'(hs), 32'(HS_ACK));
        chk({tag, "_len"}, 32'(n), 32'(pk_len[i]));
        chk({tag, "_tog"}, 32'(tg), 32'(pk_tog[i]));
        chk({tag, "_addr"}, 32'(ra), 32'(pk_addr[i] % 256));
        for (int j = 0; j < n && j < pk_len[i]; j++)
            chk({tag, "_byte"}, 32'(cap[j]), 32'(mem[(pk_addr[i] + j) % 256]));
    endtask

    task automatic run_xfer(input string tag, input int first);
        int n; logic [1:0] hs; logic tg; logic [7:0] ra;
        for (int i = first; i < npk; i++) begin
            do_in(4'(EP), 1'b1, 1'b1, (i == npk - 1), n, hs, tg, ra);
            check_pkt(tag, i, n, hs, tg, ra);
        end
    endtask

    task automatic setup_abort();
        @(negedge clk_48);
        endpoint = 4'(EP); setup = 1'b1; direction_in = 1'b0; transaction_active = 1'b1;
        m_busy = 1'b0;
        repeat (3) @(negedge clk_48);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(data_in_valid), 32'd0);
        transaction_active = 1'b0; setup = 1'b0;
        repeat (2) @(negedge clk_48);
    endtask

    initial begin
        #600000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] desc [18];
        int n; logic [1:0] hs; logic tg; logic [7:0] ra;
        desc = '{8'h12, 8'h01, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h34,
                 8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
        for (int i = 0; i < 18; i++) mem[i] = desc[i];

        // reset values
        repeat (3) @(negedge clk_48);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_toggle", 32'(data_toggle), 32'd0);
        chk("rst_handshake", 32'(handshake), 32'(HS_NAK));
        chk("rst_data_in", 32'(data_in), 32'd0);
        chk("rst_valid", 32'(data_in_valid), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk_48);

        // idle IN token -> NAK, nothing sent; stall -> STALL
        do_in(4'(EP), 1'b0, 1'b0, 1'b0, n, hs, tg, ra);
        chk("idle_hs", 32'(hs), 32'(HS_NAK));
        chk("idle_len", 32'(n), 32'd0);
        @(negedge clk_48); stall = 1'b1;
        repeat (2) @(negedge clk_48);
        chk("idle_stall_hs", 32'(handshake), 32'(HS_STALL));
        stall = 1'b0;
        repeat (2) @(negedge clk_48);

        // 18-byte descriptor, one packet
        do_load(18, 1'b1, 1'b0);
        chk("desc_npk", 32'(npk), 32'd1);
        run_xfer("desc", 0);
        chk("desc_b0", 32'(cap[0]), 32'h12);
        chk("desc_b7", 32'(cap[7]), 32'h40);
        chk("desc_busy_after", 32'(busy), 32'd0);

        // 130 bytes -> 64/64/2 with toggles 1/0/1
        do_load(130, 1'b1, 1'b0);
        chk("x130_npk", 32'(npk), 32'd3);
        chk("x130_len2", 32'(pk_len[2]), 32'd2);
        chk("x130_tog1", 32'(pk_tog[1]), 32'd0);
        chk("x130_tog2", 32'(pk_tog[2]), 32'd1);
        run_xfer("x130", 0);

        // 64 bytes with and without trailing ZLP
        do_load(64, 1'b1, 1'b1);
        chk("zlp_npk", 32'(npk), 32'd2);
        chk("zlp_len1", 32'(pk_len[1]), 32'd0);
        chk("zlp_tog1", 32'(pk_tog[1]), 32'd0);
        run_xfer("zlp", 0);
        do_load(64, 1'b1, 1'b0);
        chk("nozlp_npk", 32'(npk), 32'd1);
        run_xfer("nozlp", 0);

        // missing ACK -> identical retransmission from address 0
        do_load(64, 1'b0, 1'b0);
        do_in(4'(EP), 1'b0, 1'b0, 1'b0, n, hs, tg, ra);
        check_pkt("nak1", 0, n, hs, tg, ra);
        run_xfer("retx", 0);

        // zero-length transfer
        do_load(0, 1'b1, 1'b0);
        chk("len0_npk", 32'(npk), 32'd1);
        run_xfer("len0", 0);

        // stall while READY: STALL answered, nothing sent, then normal transfer
        do_load(18, 1'b0, 1'b0);
        @(negedge clk_48); stall = 1'b1;
        do_in(4'(EP), 1'b0, 1'b0, 1'b0, n, hs, tg, ra);
        chk("stall_hs", 32'(hs), 32'(HS_STALL));
        chk("stall_len", 32'(n), 32'd0);
        stall = 1'b0;
        run_xfer("post_stall", 0);

        // load ignored while busy, IN on other endpoint ignored, SETUP abort
        do_load(130, 1'b1, 1'b0);
        do_in(4'(EP), 1'b1, 1'b1, 1'b0, n, hs, tg, ra);
        check_pkt("ab0", 0, n, hs, tg, ra);
        @(negedge clk_48); load = 1'b1; load_len = 8'd5; load_toggle = 1'b1;
        @(negedge clk_48); load = 1'b0;
        do_in(4'd1, 1'b1, 1'b0, 1'b0, n, hs, tg, ra);
        chk("ep1_len", 32'(n), 32'd0);
        do_in(4'(EP), 1'b1, 1'b1, 1'b0, n, hs, tg, ra);
        check_pkt("ab1", 1, n, hs, tg, ra);
        setup_abort();

        // reset mid-transfer
        do_load(130, 1'b0, 1'b0);
        do_in(4'(EP), 1'b1, 1'b1, 1'b0, n, hs, tg, ra);
        check_pkt("mr0", 0, n, hs, tg, ra);
        @(negedge clk_48); rst = 1'b1; m_busy = 1'b0; m_toggle = 1'b0;
        @(negedge clk_48); rst = 1'b0;
        chk("mr_toggle", 32'(data_toggle), 32'd0);
        chk("mr_rd_addr", 32'(rd_addr), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_48);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_in_ep_tx.md
Name: usb_in_ep_tx

Overview:
IN-direction endpoint transmitter for the usbcorev-based device. It holds a pending transfer (length plus start toggle) and fetches payload bytes from a synchronous byte store, such as a descriptor ROM or response RAM. It splits the transfer into MAX_PKT-sized packets and feeds them to the usb core on IN tokens, managing DATA0/DATA1 toggling, zero-length packets and retransmission. It is the counterpart of the OUT/SETUP byte-capture logic on the same core interface.

Parameters:
EP_NUM, 0, endpoint number this block answers.
MAX_PKT, 64, max packet size in bytes (1..64).
LEN_W, 8, width of transfer length and byte address.

Ports:
clk_48  in  1  48 MHz system clock.
rst  in  1  synchronous reset, active-high.
load  in  1  one-cycle pulse: accept new transfer (ignored while busy=1).
load_len  in  LEN_W  transfer length in bytes (0 allowed).
load_toggle  in  1  data toggle of the first packet.
load_zlp  in  1  append a ZLP when load_len is a nonzero multiple of MAX_PKT.
stall  in  1  level: answer STALL to IN tokens on EP_NUM.
busy  out  1  transfer pending or in progress.
done  out  1  one-cycle pulse: last packet ACKed.
rd_addr  out  LEN_W  byte store address.
rd_data  in  8  byte store data, valid 1 cycle after rd_addr.
endpoint  in  4  from core.
direction_in  in  1  from core.
setup  in  1  from core.
transaction_active  in  1  from core.
data_strobe  in  1  from core: byte consumed (edge-detected internally).
success  in  1  from core: ACK received.
data_toggle  out  1  to core.
handshake  out  2  to core: 00 ACK, 01 none, 10 NAK, 11 STALL.
data_in  out  8  to core.
data_in_valid  out  1  to core.

Behaviour:
- Reset values: busy=0, done=0, rd_addr=0, data_toggle=0, handshake=NAK (10), data_in=0, data_in_valid=0; state IDLE.
- Tracked registers: base (packet start address), remaining, pkt_len = min(remaining, MAX_PKT), zlp_pend.
- State IDLE: handshake=NAK.
  - load=1 latches base=0, remaining=load_len, data_toggle=load_toggle, zlp_pend = load_zlp && load_len!=0 && load_len%MAX_PKT==0.
  - Moves to READY and sets busy=1.
- State READY: handshake=ACK.
  - A rising edge of transaction_active with endpoint==EP_NUM, direction_in=1, setup=0 sets rd_addr=base and moves to FETCH.
  - Tokens on any other endpoint or in any other direction are ignored.
- State FETCH: one cycle for rd_data latency, then SEND.
- State SEND:
  - If pkt_len>0: data_in=rd_data and data_in_valid=1. On each strobe edge, count the byte, increment rd_addr, and update data_in one cycle later.
  - After pkt_len strobes, or immediately if pkt_len==0, drive data_in_valid=0 and move to WAIT_END.
- State WAIT_END: wait for the falling edge of transaction_active.
  - success seen during the transaction: base+=pkt_len, remaining-=pkt_len, toggle data_toggle.
    - If remaining is still >0, go to READY.
    - Else if zlp_pend, clear zlp_pend and go to READY; the next packet is a ZLP.
    - Else pulse done, clear busy, go to IDLE.
  - No success: base, remaining and toggle are unchanged and the state returns to READY, so the same packet is retransmitted.
- stall=1 overrides handshake to STALL in every state; no data is sent and the state is held.
- A SETUP transaction starting on EP_NUM (setup=1 at the transaction_active rising edge) aborts from any state: IDLE, busy=0, data_in_valid=0, no done pulse.
- load_len=0 sends exactly one ZLP with load_toggle.
- A load pulse on the same cycle as the abort condition is ignored.
- rst mid-transfer returns the block to the reset values on the next edge.
- Address arithmetic is modulo 2^LEN_W.

Decomposition:
- Shared package usb_pkg: handshake codes (HS_ACK, HS_NONE, HS_NAK, HS_STALL), state encoding, a MAX_PKT default constant.
- Rising-edge detector for data_strobe and transaction_active: small sub-module usb_edge_det, also reusable by the OUT capture logic.

Test Plan:
- Idle IN token on EP0 -> handshake=NAK, data_in_valid never set; stall=1 -> handshake=STALL.
- Load 18-byte descriptor (12 01 02 00 FF FF FF 40 ...), toggle=1, one IN with ACK -> 18 bytes in order, data_toggle=1, done pulse, busy=0.
- load_len=130, MAX_PKT=64, toggle=1, all ACKed -> packets of 64/64/2 bytes, toggles 1/0/1, single done pulse after the third.
- load_len=64, load_zlp=1 -> 64-byte packet (toggle 1), then ZLP (toggle 0), then done; with load_zlp=0 -> done after the first packet.
- First IN without success -> second IN resends the same 64 bytes with the same toggle; rd_addr restarts at 0.
- SETUP on EP0 mid-transfer -> busy=0, data_in_valid=0, no done; IN token on EP1 -> ignored.
